// File: rtl/onewire_slave.sv
// Standard-speed 1-Wire responder: reset/presence, write-slot byte receive, read-slot byte transmit.
// Defining ONEWIRE_SLAVE_READ_ROM_EN adds an autonomous ROM_ID read-out after a leading 8'h33.
`timescale 1ns/1ps
module onewire_slave #(
    parameter int unsigned CLOCK_RATE_HZ = 50000000,
    parameter int unsigned RESET_US      = 400,
    parameter int unsigned SAMPLE_US     = 30,
    parameter int unsigned HOLD0_US      = 45,
    parameter logic [63:0] ROM_ID        = 64'h0000_0000_0000_0001
) (
    input  logic       clock,
    input  logic       clock_areset_n,
    input  logic       onewire_in,
    output logic       onewire_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       bus_reset
);
    localparam int unsigned DIV = (CLOCK_RATE_HZ / 1000000 > 0) ? CLOCK_RATE_HZ / 1000000 : 1;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int UW = $clog2(RESET_US + SAMPLE_US + HOLD0_US + 160) + 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam logic [UW-1:0] T_ONE     = UW'(1);
    localparam logic [UW-1:0] T_RESET   = UW'(RESET_US);
    localparam logic [UW-1:0] T_SAMPLE  = UW'(SAMPLE_US);
    localparam logic [UW-1:0] T_HOLD0   = UW'(HOLD0_US);
    localparam logic [UW-1:0] T_PWAIT   = UW'(30);
    localparam logic [UW-1:0] T_PDRIVE  = UW'(120);

    typedef enum logic [2:0] {IDLE, LOW, PRES_WAIT, PRES_DRIVE, SLOT_RX, SLOT_TX} state_t;

    state_t        state, state_next;
    logic          line_meta, line, line_prev;
    logic [PW-1:0] pre_cnt;
    logic [UW-1:0] us_cnt;
    logic [2:0]    bit_idx;
    logic          tx_mode, done;
    logic [7:0]    rx_shift, tx_shift, rx_byte;
    logic          tick, fall, us_clr, reset_hit;
    logic          sample_rx, sample_tx, tx_load;
    logic          rom_mode, rom_start;
    logic [2:0]    rom_byte;

    assign tick      = (pre_cnt == PRE_LAST);
    assign fall      = line_prev & ~line;
    assign rx_byte   = {line, rx_shift[7:1]};
    assign reset_hit = !line && (us_cnt >= T_RESET) && (state != PRES_WAIT) && (state != PRES_DRIVE);
    assign sample_rx = (state == SLOT_RX) && !done && (us_cnt >= T_SAMPLE);
    assign sample_tx = (state == SLOT_TX) && !done && (us_cnt >= T_HOLD0);
    assign tx_load   = (state == IDLE) && fall && (bit_idx == 3'd0) && (tx_valid || rom_mode);
    // Presence timing restarts once the host releases and again when driving begins.
    assign us_clr    = fall || ((state == PRES_WAIT) && (!line || state_next == PRES_DRIVE));

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            line_meta <= 1'b1;
            line      <= 1'b1;
            line_prev <= 1'b1;
            pre_cnt   <= '0;
            us_cnt    <= '0;
            state     <= IDLE;
            bit_idx   <= '0;
            tx_mode   <= 1'b0;
            done      <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
        end else begin
            line_meta <= onewire_in;
            line      <= line_meta;
            line_prev <= line;
            pre_cnt   <= tick ? '0 : pre_cnt + PW'(1);
            if (us_clr)
                us_cnt <= '0;
            else if (tick && us_cnt != '1)
                us_cnt <= us_cnt + UW'(1);
            state    <= state_next;
            rx_valid <= 1'b0;
            if (reset_hit) begin
                bit_idx <= '0;
                tx_mode <= 1'b0;
                done    <= 1'b0;
            end else begin
                if (state == IDLE && fall) begin
                    done <= 1'b0;
                    if (bit_idx == 3'd0)
                        tx_mode <= tx_valid || rom_mode;
                end
                if (sample_rx || sample_tx) begin
                    done    <= 1'b1;
                    bit_idx <= bit_idx + 3'd1;
                end
                if (sample_rx && bit_idx == 3'd7 && !rom_start) begin
                    rx_valid <= 1'b1;
                    rx_data  <= rx_byte;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (sample_rx)
            rx_shift <= rx_byte;
        if (tx_load)
            tx_shift <= rom_mode ? ROM_ID[{rom_byte, 3'b000} +: 8] : tx_data;
        else if (sample_tx)
            tx_shift <= {1'b0, tx_shift[7:1]};
    end

`ifdef ONEWIRE_SLAVE_READ_ROM_EN
    logic first_byte;

    assign rom_start = sample_rx && (bit_idx == 3'd7) && first_byte && (rx_byte == 8'h33);

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            first_byte <= 1'b0;
            rom_mode   <= 1'b0;
            rom_byte   <= '0;
        end else if (reset_hit) begin
            first_byte <= 1'b0;
            rom_mode   <= 1'b0;
            rom_byte   <= '0;
        end else begin
            if (state == PRES_DRIVE && state_next == IDLE)
                first_byte <= 1'b1;
            else if ((sample_rx || sample_tx) && bit_idx == 3'd7)
                first_byte <= 1'b0;
            if (rom_start)
                rom_mode <= 1'b1;
            // Byte counter wraps to zero as the last ROM byte completes.
            if (rom_mode && sample_tx && bit_idx == 3'd7) begin
                rom_byte <= rom_byte + 3'd1;
                if (rom_byte == 3'd7)
                    rom_mode <= 1'b0;
            end
        end
    end
`else
    assign rom_mode  = 1'b0;
    assign rom_byte  = 3'd0;
    assign rom_start = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (fall) state_next = LOW;
            LOW:        if (us_cnt >= T_ONE) state_next = tx_mode ? SLOT_TX : SLOT_RX;
            SLOT_RX,
            SLOT_TX:    if (done && line) state_next = IDLE;
            PRES_WAIT:  if (line && us_cnt >= T_PWAIT) state_next = PRES_DRIVE;
            PRES_DRIVE: if (us_cnt >= T_PDRIVE) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
        if (reset_hit)
            state_next = PRES_WAIT;
    end

    always_comb begin
        onewire_oe = (state == PRES_DRIVE) || ((state == SLOT_TX) && !done && !tx_shift[0]);
        tx_ready   = tx_load && !rom_mode;
        bus_reset  = reset_hit;
    end

endmodule

// File: tb/tb_onewire_slave.sv
// Directed bench for onewire_slave: a host drives slots onto a wired-AND pad model at 4 clocks per us.
`timescale 1ns/1ps
module tb_onewire_slave;
    logic       clock = 1'b0;
    logic       clock_areset_n;
    logic       host_low;
    logic       onewire_in;
    logic       onewire_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       bus_reset;

    int chk_cnt = 0;
    int err_cnt = 0;
    int rx_cnt  = 0;
    int txr_cnt = 0;
    int rst_cnt = 0;
    int oe_cyc  = 0;
    logic [7:0] rx_last = 8'h00;

    always #125 clock = ~clock;
    assign onewire_in = ~(host_low | onewire_oe);

    onewire_slave #(
        .CLOCK_RATE_HZ(4000000),
        .ROM_ID(64'h1122334455667788)
    ) dut (
        .clock(clock),
        .clock_areset_n(clock_areset_n),
        .onewire_in(onewire_in),
        .onewire_oe(onewire_oe),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .bus_reset(bus_reset)
    );

    always @(negedge clock) begin
        if (rx_valid) begin
            rx_cnt  = rx_cnt + 1;
            rx_last = rx_data;
        end
        if (tx_ready)   txr_cnt = txr_cnt + 1;
        if (bus_reset)  rst_cnt = rst_cnt + 1;
        if (onewire_oe) oe_cyc  = oe_cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_us(input int n);
        #(n * 1000);
    endtask

    task automatic wait_oe(input logic level, input int max, output int n);
        n = 0;
        while (onewire_oe !== level && n < max) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic write_bit(input logic b);
        host_low = 1'b1;
        wait_us(b ? 6 : 60);
        host_low = 1'b0;
        wait_us(b ? 64 : 10);
    endtask

    task automatic write_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) write_bit(d[i]);
    endtask

    task automatic read_bit(output logic b, output int oe_n);
        int o0;
        o0 = oe_cyc;
        host_low = 1'b1;
        wait_us(2);
        host_low = 1'b0;
        wait_us(13);
        b = onewire_in;
        wait_us(55);
        oe_n = oe_cyc - o0;
    endtask

    // A 0 bit holds the pad for 44 us after the 1 us decision point: about 176 clocks.
    task automatic read_byte(output logic [7:0] d, inout int bad);
        logic b;
        int n;
        for (int i = 0; i < 8; i++) begin
            read_bit(b, n);
            if (i == 0) tx_valid = 1'b0;
            d[i] = b;
            if (b == 1'b0 && (n < 172 || n > 180)) bad++;
            if (b == 1'b1 && n != 0) bad++;
        end
    endtask

    task automatic bus_reset_seq(input int low_us, output int d_pres, output int w_pres);
        host_low = 1'b1;
        wait_us(low_us);
        host_low = 1'b0;
        wait_oe(1'b1, 200, d_pres);
        wait_oe(1'b0, 700, w_pres);
        wait_us(10);
    endtask

    initial begin
        int r0, t0, s0, o0, dp, wp, bad;
        logic [7:0] rd, wv;
        logic [63:0] rom_rd;

        host_low       = 1'b0;
        tx_valid       = 1'b0;
        tx_data        = 8'h00;
        clock_areset_n = 1'b0;
        wait_us(2);
        check("rst_oe", 64'(onewire_oe), 64'd0);
        check("rst_rx_data", 64'(rx_data), 64'h00);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_tx_ready", 64'(tx_ready), 64'd0);
        check("rst_bus_reset", 64'(bus_reset), 64'd0);
        clock_areset_n = 1'b1;
        wait_us(2);

        s0 = rst_cnt;
        bus_reset_seq(480, dp, wp);
        check("reset_pulse_count", 64'(rst_cnt - s0), 64'd1);
        check("pres_delay_in_range", 64'(dp >= 114 && dp <= 128), 64'd1);
        check("pres_width_in_range", 64'(wp >= 470 && wp <= 490), 64'd1);

        r0 = rx_cnt; t0 = txr_cnt; bad = 0;
        tx_data = 8'h3C; tx_valid = 1'b1;
        read_byte(rd, bad);
        check("read_3c_data", 64'(rd), 64'h3C);
        check("read_3c_oe_timing_bad", 64'(bad), 64'd0);
        check("read_3c_tx_ready", 64'(txr_cnt - t0), 64'd1);
        check("read_3c_no_rx", 64'(rx_cnt - r0), 64'd0);

        r0 = rx_cnt; t0 = txr_cnt;
        write_byte(8'hA5);
        check("write_a5_rx_count", 64'(rx_cnt - r0), 64'd1);
        check("write_a5_rx_data", 64'(rx_last), 64'hA5);

        r0 = rx_cnt; t0 = txr_cnt; wv = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                tx_data  = 8'hC3;
                tx_valid = 1'b1;
            end
            write_bit(wv[i]);
        end
        check("midbyte_rx_data", 64'(rx_last), 64'h5A);
        check("midbyte_rx_count", 64'(rx_cnt - r0), 64'd1);
        check("midbyte_no_tx_ready", 64'(txr_cnt - t0), 64'd0);
        bad = 0;
        read_byte(rd, bad);
        check("next_byte_read_c3", 64'(rd), 64'hC3);
        check("next_byte_tx_ready", 64'(txr_cnt - t0), 64'd1);
        check("read_c3_oe_timing_bad", 64'(bad), 64'd0);

        r0 = rx_cnt; s0 = rst_cnt; wv = 8'h0D;
        for (int i = 0; i < 4; i++) write_bit(wv[i]);
        bus_reset_seq(500, dp, wp);
        check("abort_no_rx", 64'(rx_cnt - r0), 64'd0);
        check("abort_reset_pulse", 64'(rst_cnt - s0), 64'd1);
        check("abort_presence_ok", 64'(dp >= 114 && dp <= 128 && wp >= 470 && wp <= 490), 64'd1);
        write_byte(8'h01);
        check("after_abort_rx_data", 64'(rx_last), 64'h01);
        check("after_abort_rx_count", 64'(rx_cnt - r0), 64'd1);

        bus_reset_seq(480, dp, wp);
        r0 = rx_cnt; t0 = txr_cnt;
        write_byte(8'h33);
`ifdef ONEWIRE_SLAVE_READ_ROM_EN
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            read_byte(rd, bad);
            rom_rd[k*8 +: 8] = rd;
        end
        check("rom_id_read", rom_rd, 64'h1122334455667788);
        check("rom_oe_timing_bad", 64'(bad), 64'd0);
        check("rom_no_rx_valid", 64'(rx_cnt - r0), 64'd0);
        check("rom_no_tx_ready", 64'(txr_cnt - t0), 64'd0);
        write_byte(8'h42);
        check("post_rom_rx_data", 64'(rx_last), 64'h42);
        check("post_rom_rx_count", 64'(rx_cnt - r0), 64'd1);
`else
        rom_rd = 64'd0;
        check("cmd33_rx_data", 64'(rx_last) | rom_rd, 64'h33);
        check("cmd33_rx_count", 64'(rx_cnt - r0), 64'd1);
`endif

        tx_data = 8'h00; tx_valid = 1'b1;
        host_low = 1'b1;
        wait_us(2);
        host_low = 1'b0;
        tx_valid = 1'b0;
        wait_us(18);
        check("tx0_oe_driving", 64'(onewire_oe), 64'd1);
        #10 clock_areset_n = 1'b0;
        #1;
        check("areset_oe", 64'(onewire_oe), 64'd0);
        check("areset_rx_data", 64'(rx_data), 64'h00);
        check("areset_rx_valid", 64'(rx_valid), 64'd0);
        check("areset_tx_ready", 64'(tx_ready), 64'd0);
        check("areset_bus_reset", 64'(bus_reset), 64'd0);
        #239;
        wait_us(2);
        clock_areset_n = 1'b1;
        o0 = oe_cyc;
        wait_us(200);
        check("areset_no_presence", 64'(oe_cyc - o0), 64'd0);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/onewire_slave.md
# onewire_slave

1-Wire responder (slave) for the open-drain `onewire` pad, paired with the soft-core's 1-Wire host. It detects bus reset pulses, answers with a presence pulse, and decodes host write slots into bytes for local logic. It also drives host read slots from bytes that local logic supplies. Standard speed only; all slot timing is derived from a 1 µs tick generated from `CLOCK_RATE_HZ`.

## Interface
- `CLOCK_RATE_HZ`, 50000000: system clock frequency; µs prescaler divides by `CLOCK_RATE_HZ/1000000`.
- `RESET_US`, 400: minimum low time, in µs, that counts as a bus reset.
- `SAMPLE_US`, 30: delay from a slot's falling edge to the write-slot sample point.
- `HOLD0_US`, 45: low time driven when transmitting a 0 bit.
- `ROM_ID`, 64'h0000_0000_0000_0001: device ID used only when `ONEWIRE_SLAVE_READ_ROM_EN` is defined.
- `clock` in 1: system clock; everything is on the rising edge.
- `clock_areset_n` in 1: reset is asynchronous and active-low.
- `onewire_in` in 1: raw pad level, asynchronous to `clock`.
- `onewire_oe` out 1: 1 pulls the pad low; 0 releases it. The top-level builds the tri-state from this signal.
- `rx_data` out 8: last received byte.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `tx_data` in 8: byte to transmit.
- `tx_valid` in 1: local logic has a byte pending.
- `tx_ready` out 1: one-cycle pulse when `tx_data` is captured.
- `bus_reset` out 1: one-cycle pulse when a reset pulse is recognised.

## Operation
- **Input synchroniser:** `onewire_in` passes through a 2-flop synchroniser with reset value 1. All logic uses the synchronised level `line`. A falling edge is `line` going 1→0.
- **µs tick:** a free-running prescaler produces a 1-cycle tick every `CLOCK_RATE_HZ/1e6` clocks. The µs counter clears on every falling edge of `line`.
- **States:** IDLE, LOW, PRES_WAIT, PRES_DRIVE, SLOT_RX, SLOT_TX.
- **IDLE:** waits for a falling edge, then goes to LOW. Byte direction is decided at each byte boundary (bit index 0):
  - if `tx_valid`=1, the core captures `tx_data` and pulses `tx_ready`; the next 8 slots are read slots.
  - otherwise the next 8 slots are write slots.
- **LOW (first µs after the falling edge):**
  - Receive byte: go to SLOT_RX.
  - Transmit byte: if the current bit is 0, assert `onewire_oe` and go to SLOT_TX.
  - Transmit byte, current bit 1: the pad stays released and the core goes to SLOT_TX.
- **SLOT_RX:**
  - At `SAMPLE_US`, shift `line` into the byte, LSB first.
  - After bit 7, latch `rx_data` and pulse `rx_valid`.
  - Return to IDLE when `line`=1.
- **SLOT_TX:**
  - Release `onewire_oe` at `HOLD0_US`.
  - Advance the bit index.
  - Return to IDLE when `line`=1.
- **Reset detection (overrides every state except PRES_*):**
  - If `line` stays low for ≥ `RESET_US`: release `onewire_oe`, discard any partial byte, clear the bit index, pulse `bus_reset`, then go to PRES_WAIT once `line`=1.
- **PRES_WAIT:** wait 30 µs, then go to PRES_DRIVE.
- **PRES_DRIVE:** assert `onewire_oe` for 120 µs, release it, go to IDLE. The first byte after presence is the "first byte".
- `rx_data` holds its value until the next complete byte.

## Timing
- **Reset values:** `onewire_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_ready`=0, `bus_reset`=0, state=IDLE, synchroniser=1.
- **Input latency:** 2 clocks of synchroniser delay; all µs thresholds are accurate to +1 tick/−0.
- **Handshake pulses:**
  - `rx_valid` fires in the clock after the 8th sample.
  - `tx_ready` fires in the clock of the byte's first falling edge.
  - `tx_data` is sampled only in that cycle.
- **Simultaneous events:**
  - `tx_valid` asserting mid-byte is ignored until the next byte boundary.
  - A reset during PRES_* is ignored.
  - A host that holds the line low for ≥ `RESET_US` during SLOT_TX forces `onewire_oe`=0 immediately.
- **Async reset mid-slot:** `onewire_oe` drops to 0 at once; no presence pulse is generated.

## Configuration
- **`ONEWIRE_SLAVE_READ_ROM_EN` defined:** if the first byte after presence is 8'h33, the byte is not reported and `rx_valid` stays low. The core then autonomously transmits the 8 bytes of `ROM_ID` as read slots, LSB of byte 0 first, with no `tx_ready` pulses. Normal operation resumes after the 64th bit.
- **Not defined:** 8'h33 is delivered on `rx_data` like any other byte, and `ROM_ID` is unused.

## Test plan
- **Reset and presence:** host drives low 480 µs, then releases → `bus_reset` pulses once; `onewire_oe` goes high 30 µs after release (±1 µs) and stays high 120 µs.
- **Write byte:** host writes 8'hA5 (1 bit = 6 µs low, 0 bit = 60 µs low, 70 µs slots) → one `rx_valid` pulse with `rx_data`=8'hA5.
- **Read byte:** `tx_valid`=1 with `tx_data`=8'h3C, host issues 8 read slots sampling at 15 µs → one `tx_ready` pulse; host reads 8'h3C; `onewire_oe` is low 45 µs on each 0 bit.
- **Aborted byte:** 4 write bits, then a 500 µs low → no `rx_valid`, `bus_reset`=1, presence pulse; the following write of 8'h01 reads back exactly 8'h01.
- **Read ROM (macro defined, `ROM_ID`=64'h1122334455667788):** host sends 8'h33 plus 64 read slots → host reads 88 77 66 55 44 33 22 11; no `rx_valid` and no `tx_ready` pulses.
- **Async reset during a transmitted 0 bit** → `onewire_oe`=0 in the same cycle; all outputs at their reset values.
